// File: rtl/fnd_time_display.sv
// fnd_time_display: snapshots msec/sec/min/hour once per scan frame and multiplexes them onto a 4-digit common-anode 7-seg (in: clk, reset, i_mode, i_msec, i_sec, i_min, i_hour; out: o_fnd_comm active-low digit enable, o_fnd_font active-low dp+gfedcba)
module fnd_time_display #(
  parameter int SCAN_COUNT = 100_000,
  parameter int BLINK_HALF = 50,
  parameter int BLANK_LZ   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mode,
  input  logic [6:0] i_msec,
  input  logic [6:0] i_sec,
  input  logic [6:0] i_min,
  input  logic [4:0] i_hour,
  output logic [3:0] o_fnd_comm,
  output logic [7:0] o_fnd_font
);
  localparam int CW = SCAN_COUNT > 1 ? $clog2(SCAN_COUNT) : 1;
  logic [CW-1:0] scan_cnt;
  logic [1:0] digit_sel;
  logic s_mode;
  logic [6:0] s_msec, s_sec, s_min;
  logic [4:0] s_hour;
  logic scan_last;
  logic [6:0] left, right, left_c, right_c, val, tens, ones;
  logic [3:0] digit;
  logic [7:0] seg, font_nxt;
  logic [3:0] comm_nxt;
  assign scan_last = scan_cnt == CW'(SCAN_COUNT - 1);
  always_comb begin
    left     = s_mode ? {2'b00, s_hour} : s_sec;
    right    = s_mode ? s_min : s_msec;
    left_c   = left > 7'd99 ? 7'd99 : left;
    right_c  = right > 7'd99 ? 7'd99 : right;
    val      = digit_sel[1] ? left_c : right_c;
    tens     = val / 7'd10;
    ones     = val % 7'd10;
    digit    = digit_sel[0] ? tens[3:0] : ones[3:0];
    comm_nxt = ~(4'b0001 << digit_sel);
  end
  always_comb begin
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      default: seg = 8'h90;
    endcase
    font_nxt = (BLANK_LZ != 0) && s_mode && digit_sel == 2'd3 && tens == 7'd0 ? 8'hFF :
               digit_sel == 2'd2 && s_msec < 7'(BLINK_HALF) ? {1'b0, seg[6:0]} : seg;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt   <= '0;
      digit_sel  <= '0;
      s_mode     <= 1'b0;
      s_msec     <= '0;
      s_sec      <= '0;
      s_min      <= '0;
      s_hour     <= '0;
      o_fnd_comm <= 4'b1110;
      o_fnd_font <= 8'hC0;
    end else begin
      scan_cnt   <= scan_last ? '0 : scan_cnt + 1'b1;
      o_fnd_comm <= comm_nxt;
      o_fnd_font <= font_nxt;
      if (scan_last) digit_sel <= digit_sel + 2'd1;
      if (scan_last && digit_sel == 2'd3) begin
        s_mode <= i_mode;
        s_msec <= i_msec;
        s_sec  <= i_sec;
        s_min  <= i_min;
        s_hour <= i_hour;
      end
    end
  end
endmodule

// File: tb/tb_fnd_time_display.sv
// tb_fnd_time_display: randomized scoreboard bench for fnd_time_display with BLANK_LZ=1 and BLANK_LZ=0 instances side by side
module tb_fnd_time_display;
  localparam int SCAN = 4;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  typedef struct {
    logic [3:0] comm;
    logic [7:0] f0;
    logic [7:0] f1;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_mode = 1'b0;
  logic [6:0] i_msec = '0, i_sec = '0, i_min = '0;
  logic [4:0] i_hour = '0;
  logic [3:0] comm0, comm1;
  logic [7:0] font0, font1;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int frame = 0;
  fnd_time_display #(.SCAN_COUNT(SCAN), .BLINK_HALF(50), .BLANK_LZ(1)) u0 (
    .clk(clk), .reset(reset), .i_mode(i_mode), .i_msec(i_msec), .i_sec(i_sec),
    .i_min(i_min), .i_hour(i_hour), .o_fnd_comm(comm0), .o_fnd_font(font0));
  fnd_time_display #(.SCAN_COUNT(SCAN), .BLINK_HALF(50), .BLANK_LZ(0)) u1 (
    .clk(clk), .reset(reset), .i_mode(i_mode), .i_msec(i_msec), .i_sec(i_sec),
    .i_min(i_min), .i_hour(i_hour), .o_fnd_comm(comm1), .o_fnd_font(font1));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [7:0] ref_font(int d, bit m, int ms, int s, int mi, int h, bit blank);
    int l, r, v;
    logic [7:0] f;
    l = m ? h : s;
    r = m ? mi : ms;
    if (l > 99) l = 99;
    if (r > 99) r = 99;
    case (d)
      0: v = r % 10;
      1: v = r / 10;
      2: v = l % 10;
      default: v = l / 10;
    endcase
    f = SEG[v];
    if (d == 2 && ms < 50) f[7] = 1'b0;
    if (blank && m && d == 3 && l / 10 == 0) f = 8'hFF;
    return f;
  endfunction
  task automatic push_frame(bit m, int ms, int s, int mi, int h, int first);
    exp_t e;
    for (int d = first; d < 4; d++) begin
      e.comm = ~(4'b0001 << d);
      e.f0 = ref_font(d, m, ms, s, mi, h, 1'b1);
      e.f1 = ref_font(d, m, ms, s, mi, h, 1'b0);
      exp_q.push_back(e);
    end
  endtask
  task automatic drive(bit m, int ms, int s, int mi, int h);
    i_mode = m;
    i_msec = 7'(ms);
    i_sec  = 7'(s);
    i_min  = 7'(mi);
    i_hour = 5'(h);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_comm0"}, 32'(comm0), 32'hE);
    check({tag, "_font0"}, 32'(font0), 32'hC0);
    check({tag, "_comm1"}, 32'(comm1), 32'hE);
    check({tag, "_font1"}, 32'(font1), 32'hC0);
  endtask
  task automatic run_frames(int n);
    int dm[6] = '{0, 0, 1, 0, 1, 1};
    int dms[6] = '{25, 60, 10, 120, 99, 0};
    int ds[6] = '{37, 37, 0, 120, 0, 0};
    int dmi[6] = '{0, 0, 9, 0, 127, 0};
    int dh[6] = '{0, 0, 5, 0, 23, 10};
    bit m;
    int ms, s, mi, h;
    for (int f = 0; f < n; f++) begin
      repeat (f == 0 ? 4 * SCAN - 4 : 4 * SCAN - 6) @(negedge clk);
      if (frame < 6) begin
        m = dm[frame][0]; ms = dms[frame]; s = ds[frame]; mi = dmi[frame]; h = dh[frame];
      end else begin
        m = 1'($urandom_range(0, 1)); ms = $urandom_range(0, 127); s = $urandom_range(0, 127);
        mi = $urandom_range(0, 127); h = $urandom_range(0, 31);
      end
      frame++;
      drive(m, ms, s, mi, h);
      push_frame(m, ms, s, mi, h, 0);
      repeat (6) @(negedge clk);
      drive(~m, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 31));
    end
  endtask
  initial begin
    logic [3:0] prev;
    int cyc;
    exp_t e;
    prev = 4'b1110;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev = 4'b1110;
        cyc = 0;
      end else begin
        cyc++;
        check("onehot_comm", 32'($countones(~comm0) == 1 && comm0 === comm1), 32'd1);
        if (comm0 !== prev) begin
          prev = comm0;
          if (exp_q.size() == 0) check("unexpected_digit", 32'(comm0), 32'hF);
          else begin
            e = exp_q.pop_front();
            check("slot_timing", 32'((cyc - 1) % SCAN), 32'd0);
            check("comm", 32'(comm0), 32'(e.comm));
            check("font_blank_lz1", 32'(font0), 32'(e.f0));
            check("font_blank_lz0", 32'(font1), 32'(e.f1));
          end
        end
      end
    end
  end
  initial begin
    int waited;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    reset = 1'b0;
    push_frame(1'b0, 0, 0, 0, 0, 1);
    run_frames(14);
    repeat (7) @(negedge clk);
    check("pre_reset_comm", 32'(comm0), 32'hB);
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_reset_vals("reset_hold2");
    reset = 1'b0;
    push_frame(1'b0, 0, 0, 0, 0, 1);
    run_frames(30);
    waited = 0;
    while (exp_q.size() != 0 && waited < 8 * SCAN) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
